ctrl_actuator: RTL and testbench
================================

# ctrl_actuator

Output-side counterpart of the button/encoder control block. It takes the registered control state (`rate`, `bell`, `led`, `rgb`, `lock`, `rgb_mode`) and turns it into physical drive signals:

- a soft-ramped motor PWM, gated by lock;
- a patterned buzzer tone;
- a headlight enable;
- three RGB PWM channels (static colours or breathing).

It sits between the control block and the board pins.

## Interface
Parameters:
- `PWM_BITS`, 8: PWM counter width. Must be at least 4.
- `PWM_DIV`, 4: clocks per PWM counter step. Must be at least 1.
- `TONE_HALF`, 25000: clocks per buzzer half-period.
- `BEEP_TICKS`, 20_000_000: clocks per beep-on and per beep-off phase.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-low (`rst`=0 resets).
- `rate`  in  2: motor speed level 0..3.
- `bell`  in  1: buzzer enable.
- `led`  in  1: headlight enable.
- `rgb`  in  1: RGB strip enable.
- `lock`  in  1: motor lock.
- `rgb_mode`  in  3: RGB pattern select.
- `motor_pwm`  out  1: motor drive.
- `buzzer`  out  1: buzzer square wave.
- `head_led`  out  1: headlight.
- `rgb_r`, `rgb_g`, `rgb_b`  out  1 each: RGB channel PWM.

## Operation
**PWM base**
- Prescaler `div_cnt` counts 0..`PWM_DIV`-1.
- `pwm_cnt` (`PWM_BITS`) increments when `div_cnt` wraps. It wraps from max to 0.
- Period end (`pend`) = 1-cycle pulse when `pwm_cnt` wraps.

**Motor**
- Target duty = `rate` << (`PWM_BITS`-2): 0, 1/4, 1/2, 3/4 of full scale.
- `duty_cur` moves toward the target by STEP = 1 << (`PWM_BITS`-4) on each `pend`. It never overshoots: if the remaining distance is below STEP, it lands exactly on the target.
- `motor_pwm` = (`pwm_cnt` < `duty_cur`), registered.
- `lock`=1 does two things on the next clock: `duty_cur` is cleared to 0 and `motor_pwm` is forced to 0. The ramp is held at 0 while `lock`=1.
- On unlock, the ramp restarts from 0.

**Buzzer FSM: IDLE, ON, OFF**
- IDLE → ON when `bell`=1. The tone counter and phase counter are cleared at entry.
- ON: `buzzer` toggles every `TONE_HALF` clocks, starting at 1 on the first ON cycle. After `BEEP_TICKS` clocks → OFF.
- OFF: `buzzer`=0. After `BEEP_TICKS` clocks → ON.
- Any state with `bell`=0 → IDLE on the next clock, with `buzzer`=0 on that same edge.

**Headlight**
- `head_led` = `led`, registered.

**RGB**
- `rgb`=0: all three channel levels are 0.
- Modes 0..6 are static, at full level (all ones) on the listed channels:
  - 0: R
  - 1: G
  - 2: B
  - 3: R+G
  - 4: G+B
  - 5: R+B
  - 6: R+G+B
- Mode 7 (breathing): `breath` level is applied to all three channels.
  - `breath` steps by 1 per `pend`, counting up to max, then down to 0, and repeating.
  - Direction flips on reaching max or 0; that endpoint value is held for exactly one period.
- Leaving mode 7 or setting `rgb`=0 resets `breath` to 0, direction up.
- Channel output = (`pwm_cnt` < level), registered. Full level yields duty (2^N-1)/2^N.

## Timing
- Every output is registered. Reset value of all outputs is 0; all counters are 0; the FSM is in IDLE; `duty_cur`=0.
- Reset is asserted asynchronously and released synchronously via a 2-flop release synchronizer on `rst`.
- Input-to-output latency: 1 clock for `head_led`, lock gating, and buzzer stop/start. RGB enable and mode changes take effect 1 clock after the input changes, against the current `pwm_cnt`.
- Duty targets are sampled every clock. `duty_cur` changes only on `pend` (except for lock clear), so it never glitches within a PWM period.
- Simultaneous events:
  - `lock` and a `rate` change in the same clock: lock wins.
  - `bell` deassertion mid-tone: the tone is cut immediately.
  - `rst` mid-ramp or mid-beep: immediate return to reset values.
- Inputs are assumed synchronous to `clk`, since they come from the control block's registers. No input synchronizers are used.

## Structure
- Package `ctrl_pkg`:
  - the beep state enum (IDLE/ON/OFF);
  - the 8-entry RGB colour-mask constant (3 bits per mode);
  - the mode-7 breathing code constant.
- Sub-module `bell_seq`: buzzer FSM plus tone and phase counters, with parameters `TONE_HALF` and `BEEP_TICKS`.
- The top level holds the PWM base, motor ramp, RGB logic, and reset synchronizer.

## Test plan
Parameters for the bench: `PWM_BITS`=4, `PWM_DIV`=1, `TONE_HALF`=3, `BEEP_TICKS`=20.
- **Reset release:** hold `rst`=0 for 5 clocks, then release → all outputs 0. The first `pend` occurs 16 clocks after release plus the 2-clock sync delay.
- **Motor ramp:** `rate`=0→3 → `duty_cur` goes 0,1,2,…,12 over 12 `pend`s. Then `motor_pwm` is high for 12 of each 16 clocks.
- **Lock during ramp:** set `lock`=1 while `duty_cur`=5 → `motor_pwm`=0 and `duty_cur`=0 on the next clock. Release lock → ramp restarts at 1 on the next `pend`.
- **Bell pattern:** set `bell`=1 → `buzzer` follows 1,1,1,0,0,0,… for 20 clocks, then stays 0 for 20 clocks, then repeats. Drop `bell` mid-ON → `buzzer`=0 on the next clock and FSM returns to IDLE.
- **RGB static:** `rgb`=1, `rgb_mode`=3 → `rgb_r`=`rgb_g` high 15/16 clocks, `rgb_b`=0. `rgb`=0 → all three channels 0 within 1 clock.
- **RGB breathing:** mode 7 → level rises 0..15 across 15 `pend`s, holds 15 for one period, then falls. Switching to mode 0 resets `breath` to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the actuator side of the control block:
// buzzer FSM states and the RGB pattern table.
package ctrl_pkg;

  typedef enum logic [1:0] {
    BEEP_IDLE = 2'd0,
    BEEP_ON   = 2'd1,
    BEEP_OFF  = 2'd2
  } beep_state_t;

  localparam logic [2:0] BREATH_MODE = 3'd7;

  // Channel enables per rgb_mode, bit order {b, g, r}; mode 7 drives all three with the breath level.
  localparam logic [2:0] RGB_MASK [8] = '{
    3'b001,  // 0: R
    3'b010,  // 1: G
    3'b100,  // 2: B
    3'b011,  // 3: R+G
    3'b110,  // 4: G+B
    3'b101,  // 5: R+B
    3'b111,  // 6: R+G+B
    3'b111   // 7: breathing
  };

endpackage

// File: rtl/bell_seq.sv
// Buzzer sequencer: beep-on / beep-off phases, square-wave tone during beep-on.
// rst is the already-synchronized active-low reset from the top level.
module bell_seq
  import ctrl_pkg::*;
#(
  parameter int TONE_HALF  = 25000,
  parameter int BEEP_TICKS = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic bell,
  output logic buzzer
);

  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int PW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_HALF - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(BEEP_TICKS - 1);

  beep_state_t   state_reg, state_next;
  logic [TW-1:0] tone_reg, tone_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic          buzz_reg, buzz_next;

  always_comb begin
    state_next = state_reg;
    tone_next  = tone_reg;
    phase_next = phase_reg;
    buzz_next  = buzz_reg;
    if (!bell) begin
      // Dropping bell cuts the tone on the very next edge, whatever the phase.
      state_next = BEEP_IDLE;
      tone_next  = '0;
      phase_next = '0;
      buzz_next  = 1'b0;
    end else begin
      case (state_reg)
        BEEP_IDLE: begin
          state_next = BEEP_ON;
          tone_next  = '0;
          phase_next = '0;
          buzz_next  = 1'b1;
        end
        BEEP_ON: begin
          if (phase_reg == PHASE_LAST) begin
            state_next = BEEP_OFF;
            tone_next  = '0;
            phase_next = '0;
            buzz_next  = 1'b0;
          end else begin
            phase_next = phase_reg + PW'(1);
            if (tone_reg == TONE_LAST) begin
              tone_next = '0;
              buzz_next = ~buzz_reg;
            end else begin
              tone_next = tone_reg + TW'(1);
            end
          end
        end
        BEEP_OFF: begin
          if (phase_reg == PHASE_LAST) begin
            state_next = BEEP_ON;
            tone_next  = '0;
            phase_next = '0;
            buzz_next  = 1'b1;
          end else begin
            phase_next = phase_reg + PW'(1);
          end
        end
        default: begin
          state_next = BEEP_IDLE;
          buzz_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= BEEP_IDLE;
      tone_reg  <= '0;
      phase_reg <= '0;
      buzz_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tone_reg  <= tone_next;
      phase_reg <= phase_next;
      buzz_reg  <= buzz_next;
    end
  end

  assign buzzer = buzz_reg;

endmodule

// File: rtl/ctrl_actuator.sv
// Turns registered control state into pin drives: ramped motor PWM, buzzer,
// headlight and three RGB PWM channels. PWM_BITS >= 4, PWM_DIV >= 1.
module ctrl_actuator
  import ctrl_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int PWM_DIV    = 4,
  parameter int TONE_HALF  = 25000,
  parameter int BEEP_TICKS = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rate,
  input  logic       bell,
  input  logic       led,
  input  logic       rgb,
  input  logic       lock,
  input  logic [2:0] rgb_mode,
  output logic       motor_pwm,
  output logic       buzzer,
  output logic       head_led,
  output logic       rgb_r,
  output logic       rgb_g,
  output logic       rgb_b
);

  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(PWM_DIV - 1);
  localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(1 << (PWM_BITS - 4));
  localparam logic [PWM_BITS-1:0] BREATH_TOP = {{(PWM_BITS-1){1'b1}}, 1'b0};

  // Assert asynchronously, release two clocks after rst rises.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_reg <= '0;
    else      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n = rst_sync_reg[1];

  logic [DIV_W-1:0]    div_cnt_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                div_wrap;
  logic                pend;

  assign div_wrap = (div_cnt_reg == DIV_LAST);
  assign pend     = div_wrap && (pwm_cnt_reg == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      pwm_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + DIV_W'(1);
      if (div_wrap) pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
    end
  end

  logic [PWM_BITS-1:0] duty_tgt;
  logic [PWM_BITS-1:0] duty_cur_reg, duty_next;
  logic                motor_pwm_reg;

  assign duty_tgt = {rate, {(PWM_BITS-2){1'b0}}};

  always_comb begin
    duty_next = duty_cur_reg;
    if (duty_cur_reg < duty_tgt) begin
      if ((duty_tgt - duty_cur_reg) < STEP) duty_next = duty_tgt;
      else                                  duty_next = duty_cur_reg + STEP;
    end else if (duty_cur_reg > duty_tgt) begin
      if ((duty_cur_reg - duty_tgt) < STEP) duty_next = duty_tgt;
      else                                  duty_next = duty_cur_reg - STEP;
    end
  end

  // Lock overrides any pending ramp step; duty only moves on period boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_cur_reg  <= '0;
      motor_pwm_reg <= 1'b0;
    end else begin
      if (lock)      duty_cur_reg <= '0;
      else if (pend) duty_cur_reg <= duty_next;
      motor_pwm_reg <= !lock && (pwm_cnt_reg < duty_cur_reg);
    end
  end

  logic head_led_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) head_led_reg <= 1'b0;
    else        head_led_reg <= led;
  end

  bell_seq #(
    .TONE_HALF (TONE_HALF),
    .BEEP_TICKS(BEEP_TICKS)
  ) u_bell_seq (
    .clk   (clk),
    .rst   (rst_n),
    .bell  (bell),
    .buzzer(buzzer)
  );

  logic                breath_sel;
  logic [PWM_BITS-1:0] breath_reg, breath_next;
  logic                breath_up_reg, breath_up_next;
  logic [2:0]          chan_mask;

  assign breath_sel = rgb && (rgb_mode == BREATH_MODE);
  assign chan_mask  = RGB_MASK[rgb_mode];

  // Direction flips as the level lands on an endpoint, so each endpoint lasts one period.
  always_comb begin
    breath_next    = breath_reg;
    breath_up_next = breath_up_reg;
    if (!breath_sel) begin
      breath_next    = '0;
      breath_up_next = 1'b1;
    end else if (pend) begin
      if (breath_up_reg) begin
        breath_next = breath_reg + PWM_BITS'(1);
        if (breath_reg == BREATH_TOP) breath_up_next = 1'b0;
      end else begin
        breath_next = breath_reg - PWM_BITS'(1);
        if (breath_reg == PWM_BITS'(1)) breath_up_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      breath_reg    <= '0;
      breath_up_reg <= 1'b1;
    end else begin
      breath_reg    <= breath_next;
      breath_up_reg <= breath_up_next;
    end
  end

  logic [2:0] rgb_out;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rgb
      logic [PWM_BITS-1:0] level;
      logic                chan_reg;

      always_comb begin
        level = '0;
        if (rgb && chan_mask[gi]) level = breath_sel ? breath_reg : '1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chan_reg <= 1'b0;
        else        chan_reg <= (pwm_cnt_reg < level);
      end

      assign rgb_out[gi] = chan_reg;
    end
  endgenerate

  assign motor_pwm = motor_pwm_reg;
  assign head_led  = head_led_reg;
  assign rgb_r     = rgb_out[0];
  assign rgb_g     = rgb_out[1];
  assign rgb_b     = rgb_out[2];

endmodule

// File: tb/tb_ctrl_actuator.sv
// Scoreboard bench for ctrl_actuator: stimulus queues expected high-counts over
// cycle windows, a monitor records outputs each cycle and checks matured windows.
module tb_ctrl_actuator;

  localparam int PWM_BITS   = 4;
  localparam int PWM_DIV    = 1;
  localparam int TONE_HALF  = 3;
  localparam int BEEP_TICKS = 20;
  localparam int HIST       = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] rate = 2'd3;
  logic       bell = 1'b0;
  logic       led = 1'b0;
  logic       rgb = 1'b0;
  logic       lock = 1'b0;
  logic [2:0] rgb_mode = 3'd0;
  logic       motor_pwm, buzzer, head_led, rgb_r, rgb_g, rgb_b;

  ctrl_actuator #(
    .PWM_BITS  (PWM_BITS),
    .PWM_DIV   (PWM_DIV),
    .TONE_HALF (TONE_HALF),
    .BEEP_TICKS(BEEP_TICKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rate     (rate),
    .bell     (bell),
    .led      (led),
    .rgb      (rgb),
    .lock     (lock),
    .rgb_mode (rgb_mode),
    .motor_pwm(motor_pwm),
    .buzzer   (buzzer),
    .head_led (head_led),
    .rgb_r    (rgb_r),
    .rgb_g    (rgb_g),
    .rgb_b    (rgb_b)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen; hist[e] = outputs settled after edge e.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [5:0] hist [0:HIST-1];

  int    q_start[$];
  int    q_len[$];
  int    q_sig[$];
  int    q_exp[$];
  string q_name[$];

  // sig: 0 motor_pwm, 1 buzzer, 2 head_led, 3 rgb_r, 4 rgb_g, 5 rgb_b
  task automatic expect_ones(input string name, input int start, input int len,
                             input int sig, input int exp_ones);
    q_name.push_back(name);
    q_start.push_back(start);
    q_len.push_back(len);
    q_sig.push_back(sig);
    q_exp.push_back(exp_ones);
  endtask

  task automatic at(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon_step();
    int i;
    int last;
    int ones;
    if (cyc < HIST) hist[cyc] = {rgb_b, rgb_g, rgb_r, head_led, buzzer, motor_pwm};
    i = 0;
    while (i < q_start.size()) begin
      last = q_start[i] + q_len[i] - 1;
      if (last <= cyc) begin
        ones = 0;
        for (int k = q_start[i]; k <= last; k++) ones += int'(hist[k][q_sig[i]]);
        checks++;
        if (ones != q_exp[i]) begin
          errors++;
          $display("FAIL %s cyc %0d..%0d sig %0d: got %0d high, expected %0d",
                   q_name[i], q_start[i], last, q_sig[i], ones, q_exp[i]);
        end else begin
          $display("ok   %s cyc %0d..%0d sig %0d: %0d high", q_name[i], q_start[i], last,
                   q_sig[i], ones);
        end
        q_name.delete(i);
        q_start.delete(i);
        q_len.delete(i);
        q_sig.delete(i);
        q_exp.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      mon_step();
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset release after edge 5; internal reset drops after edge 7, pwm_cnt
    // is 0 after edge 7 and every 16th edge from there (7, 23, 39, ...).
    for (int s = 0; s < 6; s++) expect_ones("reset", 1, 7, s, 0);
    for (int j = 0; j < 15; j++) expect_ones("ramp", 8 + 16 * j, 16, 0, (j < 12) ? j : 12);
    at(5);
    rst = 1'b1;

    at(30);
    led = 1'b1;
    expect_ones("head_pre", 30, 1, 2, 0);
    expect_ones("head_on", 31, 1, 2, 1);
    at(40);
    led = 1'b0;
    expect_ones("head_hold", 40, 1, 2, 1);
    expect_ones("head_off", 41, 5, 2, 0);

    at(250);
    lock = 1'b1;
    expect_ones("lock_pre", 250, 1, 0, 1);
    expect_ones("lock_hold", 251, 40, 0, 0);
    at(300);
    lock = 1'b0;
    expect_ones("unlock_wait", 301, 11, 0, 0);
    for (int j = 1; j <= 4; j++) expect_ones("reramp", 312 + 16 * (j - 1), 16, 0, j);

    // Lock again while duty is 5, on a cycle where motor_pwm is high.
    at(378);
    lock = 1'b1;
    expect_ones("lock5_pre", 378, 1, 0, 1);
    expect_ones("lock5_cut", 379, 1, 0, 0);
    expect_ones("lock5_zero", 379, 13, 0, 0);
    at(382);
    lock = 1'b0;
    expect_ones("restart1", 392, 16, 0, 1);
    expect_ones("restart2", 408, 16, 0, 2);

    at(430);
    bell = 1'b1;
    expect_ones("bell_idle", 420, 11, 1, 0);
    for (int i = 0; i < 20; i++) expect_ones("bell_on", 431 + i, 1, 1, ((i / 3) % 2 == 0) ? 1 : 0);
    expect_ones("bell_off", 451, 20, 1, 0);
    expect_ones("bell_rep", 471, 1, 1, 1);
    at(472);
    bell = 1'b0;
    expect_ones("bell_cut_pre", 472, 1, 1, 1);
    expect_ones("bell_cut", 473, 18, 1, 0);
    at(500);
    bell = 1'b1;
    expect_ones("bell_restart", 501, 3, 1, 3);
    expect_ones("bell_restart_low", 504, 1, 1, 0);
    at(510);
    bell = 1'b0;
    expect_ones("bell_stop", 511, 10, 1, 0);

    at(520);
    rgb = 1'b1;
    rgb_mode = 3'd3;
    expect_ones("rgb_pre", 520, 1, 3, 0);
    expect_ones("m3_r", 521, 16, 3, 15);
    expect_ones("m3_g", 521, 16, 4, 15);
    expect_ones("m3_b", 521, 16, 5, 0);
    at(540);
    rgb_mode = 3'd5;
    expect_ones("m5_r", 541, 16, 3, 15);
    expect_ones("m5_g", 541, 16, 4, 0);
    expect_ones("m5_b", 541, 16, 5, 15);
    at(560);
    rgb = 1'b0;
    expect_ones("rgb_off_pre", 560, 1, 3, 1);
    for (int s = 3; s < 6; s++) expect_ones("rgb_off", 561, 10, s, 0);
    at(575);
    rgb = 1'b1;
    rgb_mode = 3'd6;
    for (int s = 3; s < 6; s++) expect_ones("m6", 576, 16, s, 15);

    // Breathing: level k in the period after pend 615+16*(k-1), peak 15 then down.
    at(600);
    rgb_mode = 3'd7;
    expect_ones("breath_start", 601, 15, 3, 0);
    for (int k = 1; k <= 17; k++)
      expect_ones("breath", 616 + 16 * (k - 1), 16, 3, (k <= 15) ? k : 30 - k);
    expect_ones("breath_peak_g", 840, 16, 4, 15);
    expect_ones("breath_peak_b", 840, 16, 5, 15);
    at(890);
    rgb_mode = 3'd0;
    expect_ones("m0_r", 891, 16, 3, 15);
    expect_ones("m0_g", 891, 16, 4, 0);
    expect_ones("m0_b", 891, 16, 5, 0);
    at(910);
    rgb_mode = 3'd7;
    expect_ones("breath_reset", 911, 9, 3, 0);
    expect_ones("breath_reset_step", 920, 16, 3, 1);

    at(945);
    if (q_start.size() != 0) begin
      errors += q_start.size();
      $display("FAIL scoreboard: %0d expectations never checked, expected 0", q_start.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
